// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and default widths for the byte-level I2C master.
// Revision 1.0
`default_nettype none

package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [3:0] {
    READY    = 4'd0,
    START    = 4'd1,
    COMMAND  = 4'd2,
    SLV_ACK1 = 4'd3,
    WR       = 4'd4,
    RD       = 4'd5,
    SLV_ACK2 = 4'd6,
    MSTR_ACK = 4'd7,
    STOP     = 4'd8
  } i2c_state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_edge_detect.sv
// i2c_edge_detect: registers a level and flags its single-cycle rising and falling edges.
// Revision 1.0
`default_nettype none

module i2c_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

`default_nettype wire

// File: rtl/i2c_master_byte_fsm.sv
// i2c_master_byte_fsm: frames START, address+R/W, data bytes, ACK/NACK and STOP on data_clk edges.
// Revision 1.0
`default_nettype none

module i2c_master_byte_fsm
  import i2c_pkg::*;
#(
  parameter int ADDR_W = I2C_ADDR_W,
  parameter int DATA_W = I2C_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_clk,
  input  logic              ena,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] data_wr,
  input  logic              sda_in,
  output logic              scl_not_ena,
  output logic              sda_drive_low,
  output logic              busy,
  output logic [DATA_W-1:0] data_rd,
  output logic              ack_error
);

  localparam int CMD_W = ADDR_W + 1;
  localparam int CNT_W = $clog2((CMD_W > DATA_W) ? CMD_W : DATA_W);
  localparam logic [CNT_W-1:0] CMD_TOP  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] BYTE_TOP = CNT_W'(DATA_W - 1);

  logic rise;
  logic fall;

  i2c_state_t        state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [CMD_W-1:0]  addr_rw, addr_rw_n;
  logic [DATA_W-1:0] data_tx, data_tx_n;
  logic [DATA_W-1:0] data_rx, data_rx_n;
  logic [DATA_W-1:0] data_rd_n;
  logic              scl_not_ena_n;
  logic              sda_drive_low_n;
  logic              busy_n;
  logic              ack_error_n;
  logic              same_target;

  i2c_edge_detect u_dc_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (data_clk),
    .rise (rise),
    .fall (fall)
  );

  // Continuing a transfer is only allowed to the same slave and direction.
  assign same_target = ena && ({addr, rw} == addr_rw);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= READY;
      bit_cnt       <= BYTE_TOP;
      addr_rw       <= '0;
      data_tx       <= '0;
      data_rx       <= '0;
      data_rd       <= '0;
      scl_not_ena   <= 1'b1;
      sda_drive_low <= 1'b0;
      busy          <= 1'b0;
      ack_error     <= 1'b0;
    end else begin
      state         <= state_n;
      bit_cnt       <= bit_cnt_n;
      addr_rw       <= addr_rw_n;
      data_tx       <= data_tx_n;
      data_rx       <= data_rx_n;
      data_rd       <= data_rd_n;
      scl_not_ena   <= scl_not_ena_n;
      sda_drive_low <= sda_drive_low_n;
      busy          <= busy_n;
      ack_error     <= ack_error_n;
    end
  end

  always_comb begin
    state_n         = state;
    bit_cnt_n       = bit_cnt;
    addr_rw_n       = addr_rw;
    data_tx_n       = data_tx;
    data_rx_n       = data_rx;
    data_rd_n       = data_rd;
    scl_not_ena_n   = scl_not_ena;
    sda_drive_low_n = sda_drive_low;
    busy_n          = busy;
    ack_error_n     = ack_error;

    if (rise) begin
      case (state)
        READY: begin
          // Releasing SDA here completes the STOP condition from the previous transfer.
          sda_drive_low_n = 1'b0;
          if (ena) begin
            addr_rw_n = {addr, rw};
            data_tx_n = data_wr;
            busy_n    = 1'b1;
            state_n   = START;
          end else begin
            busy_n = 1'b0;
          end
        end
        START: begin
          sda_drive_low_n = 1'b1;
          bit_cnt_n       = CMD_TOP;
          state_n         = COMMAND;
        end
        COMMAND: begin
          sda_drive_low_n = ~addr_rw[bit_cnt];
          if (bit_cnt == '0) begin
            state_n = SLV_ACK1;
          end else begin
            bit_cnt_n = bit_cnt - 1'b1;
          end
        end
        SLV_ACK1: begin
          sda_drive_low_n = 1'b0;
          bit_cnt_n       = BYTE_TOP;
          state_n         = addr_rw[0] ? RD : WR;
        end
        WR: begin
          busy_n          = 1'b1;
          sda_drive_low_n = ~data_tx[bit_cnt];
          if (bit_cnt == '0) begin
            state_n = SLV_ACK2;
          end else begin
            bit_cnt_n = bit_cnt - 1'b1;
          end
        end
        RD: begin
          busy_n          = 1'b1;
          sda_drive_low_n = 1'b0;
          if (bit_cnt == '0) begin
            state_n = MSTR_ACK;
          end else begin
            bit_cnt_n = bit_cnt - 1'b1;
          end
        end
        SLV_ACK2: begin
          sda_drive_low_n = 1'b0;
          if (same_target) begin
            busy_n    = 1'b0;
            data_tx_n = data_wr;
            bit_cnt_n = BYTE_TOP;
            state_n   = WR;
          end else begin
            state_n = STOP;
          end
        end
        MSTR_ACK: begin
          data_rd_n = data_rx;
          if (same_target) begin
            busy_n          = 1'b0;
            sda_drive_low_n = 1'b1;
            bit_cnt_n       = BYTE_TOP;
            state_n         = RD;
          end else begin
            sda_drive_low_n = 1'b0;
            state_n         = STOP;
          end
        end
        STOP: begin
          sda_drive_low_n = 1'b1;
          busy_n          = 1'b0;
          state_n         = READY;
        end
        default: begin
          state_n = READY;
        end
      endcase
    end else if (fall) begin
      case (state)
        START: begin
          scl_not_ena_n = 1'b0;
          ack_error_n   = 1'b0;
        end
        STOP: begin
          scl_not_ena_n = 1'b1;
        end
        SLV_ACK1, SLV_ACK2: begin
          if (sda_in) begin
            ack_error_n = 1'b1;
          end
        end
        RD: begin
          data_rx_n[bit_cnt] = sda_in;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_byte_fsm.sv
// tb_i2c_master_byte_fsm: directed checks of framing, ACK handling, stretch and reset abort.
// Revision 1.0
`default_nettype none

module tb_i2c_master_byte_fsm;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_clk;
  logic       ena;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] data_wr;
  logic       sda_in;
  logic       scl_not_ena;
  logic       sda_drive_low;
  logic       busy;
  logic [7:0] data_rd;
  logic       ack_error;

  int checks   = 0;
  int failures = 0;

  logic       sda_lvl;
  logic       busy_r;
  logic [7:0] b;
  logic       ab;

  i2c_master_byte_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .data_clk      (data_clk),
    .ena           (ena),
    .addr          (addr),
    .rw            (rw),
    .data_wr       (data_wr),
    .sda_in        (sda_in),
    .scl_not_ena   (scl_not_ena),
    .sda_drive_low (sda_drive_low),
    .busy          (busy),
    .data_rd       (data_rd),
    .ack_error     (ack_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_rise();
    @(negedge clk) data_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_fall();
    @(negedge clk) data_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One data_clk period; s is what the slave presents on SDA for the falling edge.
  task automatic step(input logic s);
    do_rise();
    sda_lvl = ~sda_drive_low;
    busy_r  = busy;
    sda_in  = s;
    do_fall();
    sda_in  = 1'b1;
  endtask

  task automatic collect(input logic ack, output logic [7:0] v, output logic all_busy);
    all_busy = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      step((i == 0) ? ack : 1'b1);
      v[i]     = sda_lvl;
      all_busy = all_busy & busy_r;
    end
  endtask

  task automatic stop_tail(input string tag);
    step(1'b1);
    chk({tag, "_stop_sda"}, 32'(sda_drive_low), 32'd1);
    chk({tag, "_stop_busy"}, 32'(busy), 32'd0);
    chk({tag, "_stop_state"}, 32'(dut.state), 32'(READY));
    step(1'b1);
    chk({tag, "_release_sda"}, 32'(sda_drive_low), 32'd0);
  endtask

  task automatic to_stop(input string tag);
    step(1'b1);
    chk({tag, "_state_stop"}, 32'(dut.state), 32'(STOP));
    chk({tag, "_scl_idle"}, 32'(scl_not_ena), 32'd1);
    chk({tag, "_ack_slot_sda"}, 32'(sda_drive_low), 32'd0);
  endtask

  initial begin
    rst = 1'b1; data_clk = 1'b0; ena = 1'b0; addr = '0; rw = 1'b0;
    data_wr = '0; sda_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_state", 32'(dut.state), 32'(READY));
    chk("rst_scl", 32'(scl_not_ena), 32'd1);
    chk("rst_sda", 32'(sda_drive_low), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data_rd", 32'(data_rd), 32'h00);
    chk("rst_ack_err", 32'(ack_error), 32'd0);
    chk("rst_bit_cnt", 32'(dut.bit_cnt), 32'd7);
    @(negedge clk) rst = 1'b0;

    // Single write 0x50 / 0xA5
    addr = 7'h50; rw = 1'b0; data_wr = 8'hA5; ena = 1'b1;
    step(1'b1);
    chk("w1_busy", 32'(busy), 32'd1);
    chk("w1_state_start", 32'(dut.state), 32'(START));
    chk("w1_scl_active", 32'(scl_not_ena), 32'd0);
    step(1'b1);
    chk("w1_start_sda", 32'(sda_drive_low), 32'd1);
    collect(1'b0, b, ab);
    chk("w1_cmd", 32'(b), 32'hA0);
    chk("w1_state_ack1", 32'(dut.state), 32'(SLV_ACK1));
    chk("w1_ack_err", 32'(ack_error), 32'd0);
    ena = 1'b0;
    step(1'b1);
    chk("w1_ack1_release", 32'(sda_drive_low), 32'd0);
    chk("w1_state_wr", 32'(dut.state), 32'(WR));
    collect(1'b0, b, ab);
    chk("w1_data", 32'(b), 32'hA5);
    chk("w1_busy_held", 32'(ab), 32'd1);
    to_stop("w1");
    chk("w1_busy_in_stop", 32'(busy), 32'd1);
    stop_tail("w1");
    chk("w1_ack_err_end", 32'(ack_error), 32'd0);

    // Two-byte write 0xA5, 0x3C with no STOP in between
    data_wr = 8'hA5; ena = 1'b1;
    step(1'b1);
    step(1'b1);
    collect(1'b0, b, ab);
    chk("w2_cmd", 32'(b), 32'hA0);
    data_wr = 8'h3C;
    step(1'b1);
    collect(1'b0, b, ab);
    chk("w2_byte0", 32'(b), 32'hA5);
    step(1'b1);
    chk("w2_handshake_busy", 32'(busy), 32'd0);
    chk("w2_state_wr", 32'(dut.state), 32'(WR));
    ena = 1'b0;
    collect(1'b0, b, ab);
    chk("w2_byte1", 32'(b), 32'h3C);
    chk("w2_busy_byte1", 32'(ab), 32'd1);
    to_stop("w2");
    stop_tail("w2");

    // Single read from 0x68, slave returns 0xC3
    addr = 7'h68; rw = 1'b1; ena = 1'b1;
    step(1'b1);
    step(1'b1);
    collect(1'b0, b, ab);
    chk("r1_cmd", 32'(b), 32'hD1);
    ena = 1'b0;
    b = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      step(b[i]);
      chk("r1_sda_released", 32'(sda_drive_low), 32'd0);
    end
    chk("r1_state_rd", 32'(dut.state), 32'(RD));
    step(1'b1);
    chk("r1_state_mack", 32'(dut.state), 32'(MSTR_ACK));
    chk("r1_data_rd_early", 32'(data_rd), 32'h00);
    step(1'b1);
    chk("r1_data_rd", 32'(data_rd), 32'hC3);
    chk("r1_nack", 32'(sda_drive_low), 32'd0);
    chk("r1_state_stop", 32'(dut.state), 32'(STOP));
    chk("r1_scl_idle", 32'(scl_not_ena), 32'd1);
    stop_tail("r1");

    // Address NACK: ack_error is sticky until the next START fall
    addr = 7'h22; rw = 1'b0; data_wr = 8'h11; ena = 1'b1;
    step(1'b1);
    step(1'b1);
    collect(1'b1, b, ab);
    chk("n_cmd", 32'(b), 32'h44);
    chk("n_ack_err", 32'(ack_error), 32'd1);
    ena = 1'b0;
    step(1'b1);
    chk("n_ack_err_wr", 32'(ack_error), 32'd1);
    collect(1'b0, b, ab);
    chk("n_data", 32'(b), 32'h11);
    to_stop("n");
    stop_tail("n");
    chk("n_ack_err_idle", 32'(ack_error), 32'd1);

    // Next transaction clears ack_error, then data_clk freezes mid-WR
    addr = 7'h50; data_wr = 8'h5A; ena = 1'b1;
    do_rise();
    chk("s_ack_err_pre", 32'(ack_error), 32'd1);
    do_fall();
    chk("s_ack_err_clr", 32'(ack_error), 32'd0);
    step(1'b1);
    collect(1'b0, b, ab);
    chk("s_cmd", 32'(b), 32'hA0);
    ena = 1'b0;
    step(1'b1);
    for (int i = 7; i >= 0; i--) begin
      do_rise();
      b[i] = ~sda_drive_low;
      if (i == 4) begin
        repeat (40) @(posedge clk);
        #1;
        chk("s_hold_state", 32'(dut.state), 32'(WR));
        chk("s_hold_cnt", 32'(dut.bit_cnt), 32'd3);
        chk("s_hold_sda", 32'(sda_drive_low), 32'd0);
      end
      sda_in = (i == 0) ? 1'b0 : 1'b1;
      do_fall();
      sda_in = 1'b1;
    end
    chk("s_data", 32'(b), 32'h5A);
    chk("s_ack_err", 32'(ack_error), 32'd0);
    to_stop("s");
    stop_tail("s");

    // Reset while reading bit 4
    addr = 7'h68; rw = 1'b1; ena = 1'b1;
    step(1'b1);
    step(1'b1);
    collect(1'b0, b, ab);
    chk("x_cmd", 32'(b), 32'hD1);
    for (int i = 0; i < 4; i++) step(1'b0);
    chk("x_state_rd", 32'(dut.state), 32'(RD));
    chk("x_cnt", 32'(dut.bit_cnt), 32'd4);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("x_state", 32'(dut.state), 32'(READY));
    chk("x_scl", 32'(scl_not_ena), 32'd1);
    chk("x_sda", 32'(sda_drive_low), 32'd0);
    chk("x_busy", 32'(busy), 32'd0);
    chk("x_data_rd", 32'(data_rd), 32'h00);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
